// File: rtl/phase_datapath.sv
// Responder side of the one-hot fetch/decode/execute phase ring.
// Fetches an instruction on f, latches operands on d, and runs the ALU
// and writeback on e. Also checks that the strobe stream follows F->D->E.
//
// Strobe protocol: at most one of {f,d,e} may be high in a cycle, and it
// must name the phase currently expected. All zero is an idle cycle that
// changes nothing. Any other pattern raises the sticky phase_err, performs
// no datapath action and leaves the expected phase where it was.
module phase_datapath #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [7:0] OUT_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f,
    input  logic        d,
    input  logic        e,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    output logic [7:0]  pc,
    output logic [7:0]  out_port,
    output logic        out_valid,
    output logic        zero,
    output logic        instr_done,
    output logic        phase_err,
    output logic        illegal,
    output logic [1:0]  dbg_phase
);

    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_DECODE = 2'd1,
        PH_EXEC   = 2'd2
    } phase_t;

    phase_t      r_phase;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;
    logic [7:0]  r_opa;
    logic [7:0]  r_opb;
    logic [7:0]  r_regs [4];
    logic        r_zero;
    logic [7:0]  r_out;
    logic        r_out_valid;
    logic        r_done;
    logic        r_perr;
    logic        r_ill;

    logic [2:0]  w_strobes;
    logic        w_do_fetch;
    logic        w_do_decode;
    logic        w_do_exec;
    logic        w_bad;
    logic [3:0]  w_op;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [7:0]  w_imm;
    logic [7:0]  w_alu;
    logic        w_alu_wr;

    assign w_strobes   = {f, d, e};
    assign w_do_fetch  = (w_strobes == 3'b100) && (r_phase == PH_FETCH);
    assign w_do_decode = (w_strobes == 3'b010) && (r_phase == PH_DECODE);
    assign w_do_exec   = (w_strobes == 3'b001) && (r_phase == PH_EXEC);
    assign w_bad       = (w_strobes != 3'b000) && !(w_do_fetch || w_do_decode || w_do_exec);

    assign w_op  = r_ir[15:12];
    assign w_rd  = r_ir[11:10];
    assign w_rs  = r_ir[9:8];
    assign w_imm = r_ir[7:0];

    // ALU result and whether the executing opcode writes R[rd] and the zero flag
    always_comb begin
        w_alu    = 8'h00;
        w_alu_wr = 1'b0;
        case (w_op)
            4'd1: begin w_alu = w_imm;         w_alu_wr = 1'b1; end
            4'd2: begin w_alu = r_opa + r_opb; w_alu_wr = 1'b1; end
            4'd3: begin w_alu = r_opa - r_opb; w_alu_wr = 1'b1; end
            4'd4: begin w_alu = r_opa & r_opb; w_alu_wr = 1'b1; end
            4'd5: begin w_alu = r_opa | r_opb; w_alu_wr = 1'b1; end
            default: begin w_alu = 8'h00;      w_alu_wr = 1'b0; end
        endcase
    end

    // Phase tracker with the sticky protocol/illegal flags and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_FETCH;
            r_perr  <= 1'b0;
            r_ill   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_bad) begin
                r_perr <= 1'b1;
            end else if (w_do_fetch) begin
                r_phase <= PH_DECODE;
            end else if (w_do_decode) begin
                r_phase <= PH_EXEC;
            end else if (w_do_exec) begin
                r_phase <= PH_FETCH;
                r_done  <= 1'b1;
                if (w_op > 4'd8) r_ill <= 1'b1;
            end
        end
    end

    // Datapath: PC/IR on fetch, operand latch on decode, writeback on execute
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_ir        <= 16'h0000;
            r_opa       <= 8'h00;
            r_opb       <= 8'h00;
            r_zero      <= 1'b0;
            r_out       <= OUT_RESET;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
        end else begin
            r_out_valid <= 1'b0;
            if (w_do_fetch) begin
                r_ir <= imem_data;
                r_pc <= r_pc + 8'd1;
            end else if (w_do_decode) begin
                r_opa <= r_regs[w_rd];
                r_opb <= r_regs[w_rs];
            end else if (w_do_exec) begin
                if (w_alu_wr) begin
                    r_regs[w_rd] <= w_alu;
                    r_zero       <= (w_alu == 8'h00);
                end
                if (w_op == 4'd6) r_pc <= w_imm;
                if (w_op == 4'd7 && r_zero) r_pc <= w_imm;
                if (w_op == 4'd8) begin
                    r_out       <= r_opa;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign out_port   = r_out;
    assign out_valid  = r_out_valid;
    assign zero       = r_zero;
    assign instr_done = r_done;
    assign phase_err  = r_perr;
    assign illegal    = r_ill;
    assign dbg_phase  = r_phase;

endmodule
